// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop walk the
// operands LSB first, one bit per RUN cycle, then present the result for one DONE cycle.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, sum_r, sum_msb;
    logic [CW-1:0]    cnt;
    logic             carry, ovf_r;
    logic             last, accept, s_bit, c_bit;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = start && (state == IDLE || state == DONE);
    assign s_bit  = a_r[0] ^ b_r[0] ^ carry;
    assign c_bit  = (a_r[0] & b_r[0]) | (a_r[0] & carry) | (b_r[0] & carry);

    always_comb begin
        state_nx = state;
        sum_msb  = '0;
        sum_msb[WIDTH-1] = s_bit;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand registers shift right so the active bit is always at index 0;
    // the result enters at the MSB and lands in place after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_r   <= a;
                b_r   <= sub ? ~b : b;
                carry <= sub ? ~cin : cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                a_r   <= a_r >> 1;
                b_r   <= b_r >> 1;
                sum_r <= (sum_r >> 1) | sum_msb;
                carry <= c_bit;
                if (last) ovf_r <= carry ^ c_bit;
                else      cnt   <= cnt + 1'b1;
            end
        end
    end

    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign sum      = sum_r;
    assign cout     = carry;
    assign overflow = ovf_r;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic start8, cin8, sub8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic start1, cin1, sub1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    exp_t q8[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    function automatic exp_t model(int w, logic [31:0] aa, logic [31:0] bb, logic c, logic s);
        logic [32:0] mask, bx, full;
        exp_t e;
        mask  = (33'd1 << w) - 33'd1;
        bx    = s ? (~{1'b0, bb} & mask) : ({1'b0, bb} & mask);
        full  = ({1'b0, aa} & mask) + bx + {32'd0, (s ? ~c : c)};
        e.sum  = 8'(full & mask);
        e.cout = full[w];
        e.ovf  = (aa[w-1] == bx[w-1]) && (full[w-1] != aa[w-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp8(input string tag);
        exp_t e;
        check({tag, "_sb"}, 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
            e = q8.pop_front();
            check({tag, "_sum"},  32'(sum8), 32'(e.sum));
            check({tag, "_cout"}, 32'(cout8), 32'(e.cout));
            check({tag, "_ovf"},  32'(ovf8), 32'(e.ovf));
            check({tag, "_busy"}, 32'(busy8), 32'd0);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic op8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                       input logic c, input logic s);
        int k;
        a8 = aa; b8 = bb; cin8 = c; sub8 = s; start8 = 1'b1;
        q8.push_back(model(8, 32'(aa), 32'(bb), c, s));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start8 = 1'b0;
            a8 = ~aa;
        end while (!done8 && k < 40);
        check({tag, "_lat"}, 32'(k), 32'd9);
        cmp8(tag);
    endtask

    task automatic op1(input int idx, input logic aa, input logic bb, input logic c);
        int k;
        exp_t e;
        a1 = aa; b1 = bb; cin1 = c; sub1 = 1'b0; start1 = 1'b1;
        q1.push_back(model(1, 32'(aa), 32'(bb), c, 1'b0));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            start1 = 1'b0;
        end while (!done1 && k < 20);
        check($sformatf("w1_%0d_lat", idx), 32'(k), 32'd2);
        e = q1.pop_front();
        check($sformatf("w1_%0d_sum", idx),  32'(sum1),  32'(e.sum[0]));
        check($sformatf("w1_%0d_cout", idx), 32'(cout1), 32'(e.cout));
        @(negedge clk);
    endtask

    initial begin
        int   k;
        logic seen;
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum",  32'(sum8),  32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_ovf",  32'(ovf8),  32'd0);

        // start raised together with reset release
        reset = 1'b0;
        op8("ff_01",  8'hFF, 8'h01, 1'b0, 1'b0);
        op8("7f_01",  8'h7F, 8'h01, 1'b0, 1'b0);
        op8("05m07",  8'h05, 8'h07, 1'b0, 1'b1);
        op8("80m01",  8'h80, 8'h01, 1'b0, 1'b1);
        op8("cin_ad", 8'h3C, 8'h41, 1'b1, 1'b0);
        op8("cin_sb", 8'h10, 8'h10, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            op8($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom));

        // start held high, inputs churn during RUN
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        q8.push_back(model(8, 32'h10, 32'h20, 1'b0, 1'b0));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!done8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
            end
        end while (!done8 && k < 40);
        check("b2b1_lat", 32'(k), 32'd9);
        cmp8("b2b1");
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b1; sub8 = 1'b1;
        q8.push_back(model(8, 32'h33, 32'h44, 1'b1, 1'b1));
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!done8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
            end
        end while (!done8 && k < 40);
        check("b2b2_gap", 32'(k), 32'd9);
        cmp8("b2b2");
        start8 = 1'b0;
        @(negedge clk);
        check("b2b_idle", 32'(done8), 32'd0);

        // reset in the middle of RUN aborts with no done pulse
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", 32'(busy8), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_sum",  32'(sum8),  32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) seen = 1'b1;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        op8("post_abort", 8'hC8, 8'h64, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++)
            op1(i, 1'(i >> 2), 1'(i >> 1), 1'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port a, input, WIDTH, operand A.
REQ-006 SHALL have port b, input, WIDTH, operand B.
REQ-007 SHALL have port cin, input, 1, carry-in (borrow-in when sub=1).
REQ-008 SHALL have port sub, input, 1, mode: 0 = add, 1 = subtract.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-011 SHALL have port sum, output, WIDTH, result word.
REQ-012 SHALL have port cout, output, 1, carry-out of MSB (inverted borrow when sub=1).
REQ-013 SHALL have port overflow, output, 1, signed two's-complement overflow flag.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE using a single 1-bit full-adder cell plus a carry flip-flop, processing one bit per cycle, LSB first.
REQ-015 SHALL, in IDLE or DONE with start=1, capture a, b, cin and sub into internal registers, clear a bit counter to 0, and enter RUN next cycle.
REQ-016 SHALL initialise the carry register to cin when sub=0 and to ~cin when sub=1; operand B bits SHALL be inverted when sub=1 (result = a - b - cin mod 2^WIDTH).
REQ-017 SHALL, in RUN cycle i (i = 0..WIDTH-1), write sum bit i = a[i] ^ b'[i] ^ carry and update carry = majority(a[i], b'[i], carry).
REQ-018 SHALL leave RUN for DONE after exactly WIDTH RUN cycles; done SHALL assert in the cycle after the last bit, i.e. WIDTH+1 cycles after the start-sampling edge.
REQ-019 SHALL drive cout = final carry register value, and overflow = (carry into MSB) XOR (carry out of MSB), both valid while done=1.
REQ-020 SHALL hold sum, cout and overflow stable from done until the next accepted start.
REQ-021 SHALL assert busy in RUN only; done only in DONE; busy and done SHALL never both be 1.
REQ-022 SHALL move DONE to IDLE after one cycle unless start=1, in which case the new operation is accepted (back-to-back, no idle gap).
REQ-023 SHALL ignore start and input changes while in RUN; captured operands SHALL not change mid-operation.
REQ-024 SHALL, for WIDTH=1, produce exactly the 1-bit full-adder truth table on sum/cout after 2 cycles.
REQ-025 SHALL size the bit counter as clog2(WIDTH+1) bits, with no wrap-around inside an operation.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, enter IDLE and clear busy, done, sum, cout, overflow, carry and the bit counter to 0.
REQ-027 SHALL give reset priority over start; a reset during RUN SHALL abort the operation with no done pulse.
REQ-028 SHALL accept start on the first edge after reset deasserts.

Verification
REQ-029 SHALL pass: WIDTH=8, a=0xFF, b=0x01, cin=0, sub=0, start pulse -> after 9 cycles done=1, sum=0x00, cout=1, overflow=0.
REQ-030 SHALL pass: WIDTH=8, a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, overflow=1.
REQ-031 SHALL pass: WIDTH=8, a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, overflow=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
REQ-032 SHALL pass: start held high and a, b toggled during RUN -> result matches operands captured at first start; next operation accepted in DONE cycle, done pulses exactly 9 cycles apart.
REQ-033 SHALL pass: reset asserted at RUN cycle 3 -> next cycle busy=0, done=0, sum=0x00, and no done pulse follows until a new start.
REQ-034 SHALL pass: WIDTH=1, all 8 (a,b,cin) combinations with sub=0 -> sum/cout equal to full-adder truth table (0,0,0->0,0; 0,1,0->1,0; 1,0,1->0,1; 1,1,1->1,1, etc.).
